// File: rtl/cordic_pkg.sv
// Shared types, sizing and arctangent table for the iterative CORDIC rotator.
package cordic_pkg;

  localparam int WIDTH  = 13;
  localparam int ITER   = 12;
  localparam int ITER_W = $clog2(ITER);

  typedef logic signed [WIDTH-1:0] coord_t;
  typedef logic signed [WIDTH-1:0] angle_t;
  typedef logic [ITER_W-1:0]       iter_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam iter_t ITER_LAST = iter_t'(ITER - 1);

  // atan(2^-i) in 1/64-degree units; indices past the table contribute nothing
  function automatic angle_t atan_lut(input iter_t i);
    angle_t a;
    case (i)
      4'd0:    a = 13'sd2880;
      4'd1:    a = 13'sd1700;
      4'd2:    a = 13'sd898;
      4'd3:    a = 13'sd456;
      4'd4:    a = 13'sd229;
      4'd5:    a = 13'sd115;
      4'd6:    a = 13'sd57;
      4'd7:    a = 13'sd29;
      4'd8:    a = 13'sd14;
      4'd9:    a = 13'sd7;
      4'd10:   a = 13'sd4;
      4'd11:   a = 13'sd2;
      default: a = 13'sd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation; the sequencer reuses it every cycle.
module cordic_stage
  import cordic_pkg::*;
(
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  input  logic [ITER_W-1:0]       shift,
  input  logic signed [WIDTH-1:0] atan_val,
  output logic signed [WIDTH-1:0] x_next,
  output logic signed [WIDTH-1:0] y_next,
  output logic signed [WIDTH-1:0] z_next
);

  coord_t x_sh_s;
  coord_t y_sh_s;
  logic   d_s;

  assign x_sh_s = x >>> shift;
  assign y_sh_s = y >>> shift;
  assign d_s    = ~z[WIDTH-1];

  // Rotate toward zero residual angle; both updates read the pre-update x and y
  always_comb begin
    x_next = x;
    y_next = y;
    z_next = z;
    if (d_s) begin
      x_next = x - y_sh_s;
      y_next = y + x_sh_s;
      z_next = z - atan_val;
    end else begin
      x_next = x + y_sh_s;
      y_next = y - x_sh_s;
      z_next = z + atan_val;
    end
  end

endmodule

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC rotation controller: accepts one job, runs ITER micro-rotations
// through a single shared stage, then pulses done and holds the result.
module cordic_sequencer
  import cordic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  state_t state_r;
  state_t state_next_s;
  logic   accept_s;
  logic   last_s;
  iter_t  iter_r;
  coord_t x_r, y_r;
  angle_t z_r;
  coord_t x_nx_s, y_nx_s;
  angle_t z_nx_s;
  angle_t atan_s;
  coord_t x_out_r, y_out_r;
  angle_t z_out_r;
  logic   ready_r, busy_r, done_r;

  assign last_s = (iter_r == ITER_LAST);
  assign atan_s = atan_lut(iter_r);

  cordic_stage u_stage (
    .x        (x_r),
    .y        (y_r),
    .z        (z_r),
    .shift    (iter_r),
    .atan_val (atan_s),
    .x_next   (x_nx_s),
    .y_next   (y_nx_s),
    .z_next   (z_nx_s)
  );

  // Next-state decode; DONE with start accepts the following job on the same edge
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ROTATE;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROTATE: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ROTATE;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = ROTATE;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register; status flags are decoded from the next state so they leave flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == IDLE) || (state_next_s == DONE);
      busy_r  <= (state_next_s == ROTATE);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Working registers, iteration counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_r  <= '0;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      x_out_r <= '0;
      y_out_r <= '0;
      z_out_r <= '0;
    end else if (accept_s) begin
      iter_r <= '0;
      x_r    <= x_in;
      y_r    <= y_in;
      z_r    <= z_in;
    end else if (state_r == ROTATE) begin
      x_r <= x_nx_s;
      y_r <= y_nx_s;
      z_r <= z_nx_s;
      if (last_s) begin
        iter_r  <= '0;
        x_out_r <= x_nx_s;
        y_out_r <= y_nx_s;
        z_out_r <= z_nx_s;
      end else begin
        iter_r <= iter_r + iter_t'(1);
      end
    end
  end

  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign x_out = x_out_r;
  assign y_out = y_out_r;
  assign z_out = z_out_r;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Scoreboard bench for cordic_sequencer: expected results come from an independent
// model of the CORDIC recurrence and are popped when done pulses.
module tb_cordic_sequencer;
  import cordic_pkg::*;

  typedef logic signed [12:0] w13_t;
  typedef struct {
    w13_t x;
    w13_t y;
    w13_t z;
  } res_t;

  logic clk = 1'b0;
  logic rst, start;
  w13_t x_in, y_in, z_in;
  logic ready, busy, done;
  w13_t x_out, y_out, z_out;

  res_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   atan_tab[12] = '{2880, 1700, 898, 456, 229, 115, 57, 29, 14, 7, 4, 2};

  always #5 clk = ~clk;

  cordic_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out)
  );

  function automatic res_t ref_model(input w13_t xi, input w13_t yi, input w13_t zi);
    w13_t x, y, z, xs, ys;
    res_t r;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < 12; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - 13'(atan_tab[i]);
      end else begin
        x = x + ys; y = y - xs; z = z + 13'(atan_tab[i]);
      end
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  // Drive a job at the current negedge; returns at the negedge after the accept edge
  task automatic accept(input int xv, input int yv, input int zv);
    x_in = 13'(xv); y_in = 13'(yv); z_in = 13'(zv);
    start = 1'b1;
    sb.push_back(ref_model(x_in, y_in, z_in));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles since acceptance (1 at first negedge) until done, bounded
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({ready, busy, done} !== 3'b100) begin
      n_bad++; $display("FAIL reset_flags got=%b want=100", {ready, busy, done});
    end
    n_vec++;
    if ({x_out, y_out, z_out} !== 39'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%0d,%0d,%0d want=0,0,0", x_out, y_out, z_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int cyc, xo, yo, zo;
    res_t e;
    accept(1000, 0, 0);
    n_vec++;
    if ({ready, busy, done} !== 3'b010) begin
      n_bad++; $display("FAIL basic_busy got=%b want=010", {ready, busy, done});
    end
    wait_done(cyc);
    n_vec++;
    if (cyc !== 13) begin
      n_bad++; $display("FAIL basic_latency got=%0d want=13", cyc);
    end
    e = sb.pop_front();
    n_vec++;
    if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
      n_bad++; $display("FAIL basic_model got=%0d,%0d,%0d want=%0d,%0d,%0d", x_out, y_out, z_out, e.x, e.y, e.z);
    end
    xo = x_out; yo = y_out; zo = z_out;
    n_vec++;
    if (xo < 1643 || xo > 1651 || yo < -4 || yo > 4 || zo < -2 || zo > 2) begin
      n_bad++; $display("FAIL basic_gain got=%0d,%0d,%0d want=1647+-4,0+-4,|z|<=2", xo, yo, zo);
    end
    @(negedge clk);
    n_vec++;
    if ({ready, busy, done} !== 3'b100) begin
      n_bad++; $display("FAIL basic_pulse got=%b want=100", {ready, busy, done});
    end
    n_vec++;
    if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
      n_bad++; $display("FAIL basic_hold got=%0d,%0d,%0d want=%0d,%0d,%0d", x_out, y_out, z_out, e.x, e.y, e.z);
    end
  endtask

  task automatic test_45;
    int cyc, xo, yo, ywant;
    res_t e;
    for (int s = 0; s < 2; s++) begin
      ywant = (s == 0) ? 1164 : -1164;
      accept(1000, 0, (s == 0) ? 2880 : -2880);
      wait_done(cyc);
      n_vec++;
      if (cyc !== 13) begin
        n_bad++; $display("FAIL deg45_latency[%0d] got=%0d want=13", s, cyc);
      end
      e = sb.pop_front();
      n_vec++;
      if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
        n_bad++; $display("FAIL deg45_model[%0d] got=%0d,%0d,%0d want=%0d,%0d,%0d", s, x_out, y_out, z_out, e.x, e.y, e.z);
      end
      xo = x_out; yo = y_out;
      n_vec++;
      if (xo < 1160 || xo > 1168 || yo < ywant - 4 || yo > ywant + 4) begin
        n_bad++; $display("FAIL deg45_range[%0d] got=%0d,%0d want=1164+-4,%0d+-4", s, xo, yo, ywant);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    res_t e;
    accept(0, 1000, -5760);
    wait_done(cyc);
    n_vec++;
    if (cyc !== 13) begin
      n_bad++; $display("FAIL wrap_latency got=%0d want=13", cyc);
    end
    e = sb.pop_front();
    n_vec++;
    if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
      n_bad++; $display("FAIL wrap_model got=%0d,%0d,%0d want=%0d,%0d,%0d", x_out, y_out, z_out, e.x, e.y, e.z);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int ndone, first;
    res_t e;
    ndone = 0; first = 0;
    accept(300, -400, 1000);
    for (int c = 1; c <= 30; c++) begin
      start = (c == 3 || c == 7);
      if (start) begin
        x_in = 13'(-900); y_in = 13'(150); z_in = 13'(-3000);
      end
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = c;
          e = sb.pop_front();
          n_vec++;
          if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
            n_bad++; $display("FAIL ignore_model got=%0d,%0d,%0d want=%0d,%0d,%0d", x_out, y_out, z_out, e.x, e.y, e.z);
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    sb.delete();
    n_vec++;
    if (ndone !== 1 || first !== 13) begin
      n_bad++; $display("FAIL ignore_done got=%0d pulses at %0d want=1 pulse at 13", ndone, first);
    end
  endtask

  task automatic test_reset_mid;
    int ndone, cyc;
    res_t e;
    ndone = 0;
    accept(800, 200, -1500);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ready, busy, done} !== 3'b100) begin
      n_bad++; $display("FAIL midrst_flags got=%b want=100", {ready, busy, done});
    end
    n_vec++;
    if ({x_out, y_out, z_out} !== 39'd0) begin
      n_bad++; $display("FAIL midrst_outputs got=%0d,%0d,%0d want=0,0,0", x_out, y_out, z_out);
    end
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_vec++;
    if (ndone !== 0) begin
      n_bad++; $display("FAIL midrst_nodone got=%0d want=0", ndone);
    end
    accept(500, 500, 700);
    wait_done(cyc);
    n_vec++;
    if (cyc !== 13) begin
      n_bad++; $display("FAIL midrst_relatency got=%0d want=13", cyc);
    end
    e = sb.pop_front();
    n_vec++;
    if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
      n_bad++; $display("FAIL midrst_rejob got=%0d,%0d,%0d want=%0d,%0d,%0d", x_out, y_out, z_out, e.x, e.y, e.z);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int jx[4] = '{1000, -700, 200, -50};
    int jy[4] = '{0, 300, -900, -1200};
    int jz[4] = '{1500, -2000, 3000, -700};
    int cyc;
    res_t e;
    x_in = 13'(jx[0]); y_in = 13'(jy[0]); z_in = 13'(jz[0]);
    start = 1'b1;
    sb.push_back(ref_model(x_in, y_in, z_in));
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({ready, busy, done} !== 3'b010) begin
        n_bad++; $display("FAIL b2b_accept[%0d] got=%b want=010", k, {ready, busy, done});
      end
      if (k < 3) begin
        x_in = 13'(jx[k+1]); y_in = 13'(jy[k+1]); z_in = 13'(jz[k+1]);
      end else begin
        start = 1'b0;
      end
      wait_done(cyc);
      n_vec++;
      if (cyc !== 13) begin
        n_bad++; $display("FAIL b2b_period[%0d] got=%0d want=13", k, cyc);
      end
      e = sb.pop_front();
      n_vec++;
      if ({x_out, y_out, z_out} !== {e.x, e.y, e.z}) begin
        n_bad++; $display("FAIL b2b_model[%0d] got=%0d,%0d,%0d want=%0d,%0d,%0d", k, x_out, y_out, z_out, e.x, e.y, e.z);
      end
      if (k < 3) sb.push_back(ref_model(x_in, y_in, z_in));
      @(negedge clk);
    end
    n_vec++;
    if ({ready, busy, done} !== 3'b100) begin
      n_bad++; $display("FAIL b2b_idle got=%b want=100", {ready, busy, done});
    end
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    test_reset;
    test_basic;
    test_45;
    test_wrap;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
